// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences one shared ALU and memory port
// through fetch, decode, execute and writeback, one state per cycle.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic        instr_done,
  output logic        illegal
);

  localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(MEM_WAIT_MAX);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXECR,
    S_EXECI,
    S_EXECLUI,
    S_ALUWB,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_BRANCH,
    S_EXECJALR,
    S_JAL,
    S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          wait_out;

  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign wait_out = (wait_q == WMAX);

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    alu_op     = 2'b00;
    funct3_o   = 3'b000;
    funct7_o   = 7'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_out) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        case (instr[6:0])
          OP_R:     state_d = S_EXECR;
          OP_I:     state_d = S_EXECI;
          OP_LOAD,
          OP_STORE: state_d = S_MEMADR;
          OP_BR:    state_d = S_BRANCH;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = S_EXECJALR;
          OP_LUI:   state_d = S_EXECLUI;
          OP_AUIPC: state_d = S_ALUWB;
          default:  state_d = S_ERROR;
        endcase
      end
      S_EXECR: begin
        alu_src_a = A_RS1;
        alu_op    = 2'b10;
        funct3_o  = instr[14:12];
        funct7_o  = instr[31:25];
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = 2'b10;
        funct3_o  = instr[14:12];
        // only shifts carry a real funct7; elsewhere it is immediate bits
        if (instr[14:12] == 3'b101) funct7_o = instr[31:25];
        state_d   = S_ALUWB;
      end
      S_EXECLUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d   = instr[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)     state_d = S_MEMWB;
        else if (wait_out) state_d = S_ERROR;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (wait_out) begin
          state_d = S_ERROR;
        end
      end
      S_BRANCH: begin
        alu_src_a  = A_RS1;
        pc_src     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
        case (instr[14:12])
          3'b000: begin alu_op = 2'b01; pc_write = zero;  end
          3'b001: begin alu_op = 2'b01; pc_write = !zero; end
          3'b100: begin
            alu_op = 2'b10; funct3_o = 3'b010; pc_write = !zero;
          end
          3'b101: begin
            alu_op = 2'b10; funct3_o = 3'b010; pc_write = zero;
          end
          3'b110: begin
            alu_op = 2'b10; funct3_o = 3'b011; pc_write = !zero;
          end
          3'b111: begin
            alu_op = 2'b10; funct3_o = 3'b011; pc_write = zero;
          end
          default: begin
            pc_src     = 1'b0;
            instr_done = 1'b0;
            state_d    = S_ERROR;
          end
        endcase
      end
      S_EXECJALR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d   = S_JAL;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        reg_write  = 1'b1;
        result_src = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ERROR: illegal = 1'b1;
      default: state_d = S_ERROR;
    endcase
  end

  // counter restarts on every state change; grows only while a request stalls
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)       wait_d = '0;
    else if (mem_req && !mem_ready) wait_d = wait_q + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors
// checked against hand-derived expectations.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic        reg_write, instr_done, illegal;

  int errors = 0;
  int checks = 0;
  int rw_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_MAX(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .funct3_o   (funct3_o),
    .funct7_o   (funct7_o),
    .reg_write  (reg_write),
    .result_src (result_src),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  logic [16:0] ctl;
  assign ctl = {mem_req, mem_we, adr_src, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, result_src,
                instr_done, illegal};

  always @(negedge clk) if (reg_write) rw_cnt++;

  function automatic logic [16:0] mk(
    input logic mrq, mwe, adr, irw, pcw, pcs,
    input logic [1:0] a, b, op,
    input logic rw,
    input logic [1:0] rs,
    input logic dn, il);
    return {mrq, mwe, adr, irw, pcw, pcs, a, b, op, rw, rs, dn, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // check this cycle's outputs, then advance one clock
  task automatic cyc(input string tag, input logic [16:0] ec,
                     input logic [2:0] f3, input logic [6:0] f7);
    #1;
    chk({tag, ".ctl"}, 32'(ctl), 32'(ec));
    chk({tag, ".f3"}, 32'(funct3_o), 32'(f3));
    chk({tag, ".f7"}, 32'(funct7_o), 32'(f7));
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [16:0] C_RST, C_FR, C_FW, C_DEC, C_EXR, C_EXI, C_LUI, C_WB;
  logic [16:0] C_MADR, C_MRD, C_MWB, C_MWR, C_MWRD;
  logic [16:0] C_BRT, C_BRN, C_BRX, C_JAL, C_JALR, C_ERR;

  initial begin
    C_RST  = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,2'b00,0,0);
    C_FR   = mk(1,0,0,1,1,0,2'b00,2'b10,2'b00,0,2'b00,0,0);
    C_FW   = mk(1,0,0,0,0,0,2'b00,2'b10,2'b00,0,2'b00,0,0);
    C_DEC  = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,0,2'b00,0,0);
    C_EXR  = mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,0,2'b00,0,0);
    C_EXI  = mk(0,0,0,0,0,0,2'b10,2'b01,2'b10,0,2'b00,0,0);
    C_LUI  = mk(0,0,0,0,0,0,2'b11,2'b01,2'b00,0,2'b00,0,0);
    C_WB   = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,1,0);
    C_MADR = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,0,2'b00,0,0);
    C_MRD  = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,0,2'b00,0,0);
    C_MWB  = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,2'b01,1,0);
    C_MWR  = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,0,2'b00,0,0);
    C_MWRD = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,0,2'b00,1,0);
    C_BRT  = mk(0,0,0,0,1,1,2'b10,2'b00,2'b10,0,2'b00,1,0);
    C_BRN  = mk(0,0,0,0,0,1,2'b10,2'b00,2'b10,0,2'b00,1,0);
    C_BRX  = mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,0,2'b00,0,0);
    C_JALR = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,0,2'b00,0,0);
    C_JAL  = mk(0,0,0,0,1,1,2'b01,2'b10,2'b00,1,2'b10,1,0);
    C_ERR  = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,2'b00,0,1);

    instr = 32'h0000_0013;
    zero = 1'b0;
    mem_ready = 1'b1;
    do_rst();

    // ADD x3,x1,x2
    instr = 32'h0020_81B3;
    cyc("rst", C_RST, 3'b000, 7'h00);
    cyc("add.fetch", C_FR, 3'b000, 7'h00);
    cyc("add.dec", C_DEC, 3'b000, 7'h00);
    cyc("add.exec", C_EXR, 3'b000, 7'h00);
    cyc("add.wb", C_WB, 3'b000, 7'h00);

    // SUB x3,x1,x2 passes funct7 through
    instr = 32'h4020_81B3;
    cyc("sub.fetch", C_FR, 3'b000, 7'h00);
    cyc("sub.dec", C_DEC, 3'b000, 7'h00);
    cyc("sub.exec", C_EXR, 3'b000, 7'h20);
    cyc("sub.wb", C_WB, 3'b000, 7'h00);

    // ADDI x1,x0,-1
    instr = 32'hFFF0_0093;
    cyc("addi.fetch", C_FR, 3'b000, 7'h00);
    cyc("addi.dec", C_DEC, 3'b000, 7'h00);
    cyc("addi.exec", C_EXI, 3'b000, 7'h00);
    cyc("addi.wb", C_WB, 3'b000, 7'h00);

    // SRAI x1,x1,4
    instr = 32'h4040_D093;
    cyc("srai.fetch", C_FR, 3'b000, 7'h00);
    cyc("srai.dec", C_DEC, 3'b000, 7'h00);
    cyc("srai.exec", C_EXI, 3'b101, 7'h20);
    cyc("srai.wb", C_WB, 3'b000, 7'h00);

    // LUI x1,0x12345
    instr = 32'h1234_50B7;
    cyc("lui.fetch", C_FR, 3'b000, 7'h00);
    cyc("lui.dec", C_DEC, 3'b000, 7'h00);
    cyc("lui.exec", C_LUI, 3'b000, 7'h00);
    cyc("lui.wb", C_WB, 3'b000, 7'h00);

    // AUIPC x1,0 : 3 cycles
    instr = 32'h0000_0097;
    cyc("auipc.fetch", C_FR, 3'b000, 7'h00);
    cyc("auipc.dec", C_DEC, 3'b000, 7'h00);
    cyc("auipc.wb", C_WB, 3'b000, 7'h00);

    // BLT x1,x2,+8 with zero=0 -> taken
    instr = 32'h0020_C463;
    zero = 1'b0;
    cyc("blt.fetch", C_FR, 3'b000, 7'h00);
    cyc("blt.dec", C_DEC, 3'b000, 7'h00);
    cyc("blt.br", C_BRT, 3'b010, 7'h00);

    // BGE with zero=0 -> not taken
    instr = 32'h0020_D463;
    cyc("bge.fetch", C_FR, 3'b000, 7'h00);
    cyc("bge.dec", C_DEC, 3'b000, 7'h00);
    cyc("bge.br", C_BRN, 3'b010, 7'h00);

    // BGEU with zero=1 -> taken
    instr = 32'h0020_F463;
    zero = 1'b1;
    cyc("bgeu.fetch", C_FR, 3'b000, 7'h00);
    cyc("bgeu.dec", C_DEC, 3'b000, 7'h00);
    cyc("bgeu.br", C_BRT, 3'b011, 7'h00);
    zero = 1'b0;

    // JALR x0,0(x1) then JAL x0,0
    instr = 32'h0000_8067;
    cyc("jalr.fetch", C_FR, 3'b000, 7'h00);
    cyc("jalr.dec", C_DEC, 3'b000, 7'h00);
    cyc("jalr.exec", C_JALR, 3'b000, 7'h00);
    cyc("jalr.jal", C_JAL, 3'b000, 7'h00);
    instr = 32'h0000_006F;
    cyc("jal.fetch", C_FR, 3'b000, 7'h00);
    cyc("jal.dec", C_DEC, 3'b000, 7'h00);
    cyc("jal.jal", C_JAL, 3'b000, 7'h00);

    // SW x2,0(x1) zero-wait
    instr = 32'h0020_A023;
    cyc("sw.fetch", C_FR, 3'b000, 7'h00);
    cyc("sw.dec", C_DEC, 3'b000, 7'h00);
    cyc("sw.adr", C_MADR, 3'b000, 7'h00);
    cyc("sw.wr", C_MWRD, 3'b000, 7'h00);

    // LW x5,0(x1) with 3 wait cycles: 8 cycles, one reg_write
    instr = 32'h0000_A283;
    cyc("lw.fetch", C_FR, 3'b000, 7'h00);
    rw_cnt = 0;
    cyc("lw.dec", C_DEC, 3'b000, 7'h00);
    cyc("lw.adr", C_MADR, 3'b000, 7'h00);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw.wait", C_MRD, 3'b000, 7'h00);
    mem_ready = 1'b1;
    cyc("lw.rd", C_MRD, 3'b000, 7'h00);
    cyc("lw.wb", C_MWB, 3'b000, 7'h00);
    chk("lw.rwcnt", 32'(rw_cnt), 32'd1);

    // fetch stalls 16 cycles -> ERROR, sticky
    instr = 32'h0000_0013;
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to.fetch", C_FW, 3'b000, 7'h00);
    cyc("to.err", C_ERR, 3'b000, 7'h00);
    mem_ready = 1'b1;
    cyc("to.sticky", C_ERR, 3'b000, 7'h00);
    do_rst();
    cyc("to.rst", C_RST, 3'b000, 7'h00);

    // illegal opcode 0x7F
    instr = 32'h0000_007F;
    cyc("op7f.fetch", C_FR, 3'b000, 7'h00);
    cyc("op7f.dec", C_DEC, 3'b000, 7'h00);
    cyc("op7f.err", C_ERR, 3'b000, 7'h00);
    do_rst();
    cyc("op7f.rst", C_RST, 3'b000, 7'h00);

    // branch funct3=010 -> ERROR, no pc_write
    instr = 32'h0020_A463;
    cyc("brx.fetch", C_FR, 3'b000, 7'h00);
    cyc("brx.dec", C_DEC, 3'b000, 7'h00);
    cyc("brx.br", C_BRX, 3'b000, 7'h00);
    cyc("brx.err", C_ERR, 3'b000, 7'h00);
    do_rst();
    cyc("brx.rst", C_RST, 3'b000, 7'h00);

    // reset during a stalled store
    instr = 32'h0020_A023;
    cyc("swr.fetch", C_FR, 3'b000, 7'h00);
    cyc("swr.dec", C_DEC, 3'b000, 7'h00);
    cyc("swr.adr", C_MADR, 3'b000, 7'h00);
    mem_ready = 1'b0;
    cyc("swr.wait", C_MWR, 3'b000, 7'h00);
    rst = 1'b1;
    cyc("swr.rstcyc", C_MWR, 3'b000, 7'h00);
    rst = 1'b0;
    mem_ready = 1'b1;
    cyc("swr.rst", C_RST, 3'b000, 7'h00);
    cyc("swr.refetch", C_FR, 3'b000, 7'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle RV32I control unit: the sequencing initiator that drives the `alu` block's `alu_op`, `funct3` and `funct7` inputs and consumes its `zero` flag. It also drives the datapath mux selects, register and PC write strobes, and the memory request handshake, one state per cycle. It sits between the instruction register and the shared datapath, where one ALU and one memory port are reused across fetch, address and execute phases. Datapath contract: ALUOut and OldPC are registers loaded every cycle; OldPC is loaded with PC on `ir_write`.

## Interface
- MEM_WAIT_MAX, 15: maximum extra cycles a memory access may wait for `mem_ready` before the unit traps.
- clk  in  1  clock; every state change happens on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current instruction register contents.
- zero  in  1  ALU zero flag (result == 0).
- mem_ready  in  1  memory completes the access in this cycle.
- mem_req  out  1  memory access request; held until `mem_ready`.
- mem_we  out  1  store when 1, read when 0.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and OldPC from memory.
- pc_write  out  1  write the PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  ALU operand A: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU operand B: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  out  2  to ALU: 00 = add, 01 = subtract, 10 = decode by funct fields.
- funct3_o  out  3  funct3 presented to the ALU.
- funct7_o  out  7  funct7 presented to the ALU.
- reg_write  out  1  write rd.
- result_src  out  2  register write data: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  sticky trap flag.

## Operation
- Defaults: every output not listed for a state is 0.
- RESET: the state entered while `rst` is high. All outputs are 0. The next state is always FETCH.
- FETCH: `mem_req`=1, `adr_src`=0, A=PC, B=4, `alu_op`=00.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- DECODE: A=OldPC, B=imm, `alu_op`=00, so the branch/JAL/AUIPC target lands in ALUOut. Dispatch on `instr[6:0]`:
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0000011 and 0100011 → MEMADR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → EXECJALR
  - 0110111 → EXECLUI
  - 0010111 → ALUWB
  - any other opcode → ERROR
- EXECR: A=rs1, B=rs2, `alu_op`=10, `funct3_o`=`instr[14:12]`, `funct7_o`=`instr[31:25]`. Next: ALUWB.
- EXECI: as EXECR with B=imm. `funct7_o`=`instr[31:25]` only when funct3=101; otherwise 0, so that ADDI with imm[10]=1 never becomes SUB. Next: ALUWB.
- EXECLUI: A=zero, B=imm, `alu_op`=00. Next: ALUWB.
- ALUWB: `reg_write`=1, `result_src`=00, `instr_done`=1. Next: FETCH.
- MEMADR: A=rs1, B=imm, `alu_op`=00. Next: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: `mem_req`=1, `adr_src`=1. Next: MEMWB on `mem_ready`.
- MEMWB: `reg_write`=1, `result_src`=01, `instr_done`=1. Next: FETCH.
- MEMWRITE: `mem_req`=1, `mem_we`=1, `adr_src`=1. On `mem_ready`: `instr_done`=1, next FETCH.
- BRANCH: A=rs1, B=rs2, `pc_src`=1, `pc_write`=taken, `instr_done`=1. Next: FETCH. ALU setting and taken condition per funct3:
  - 000 BEQ: `alu_op`=01, taken when `zero`.
  - 001 BNE: `alu_op`=01, taken when !`zero`.
  - 100 BLT: `alu_op`=10, `funct3_o`=010, taken when !`zero`.
  - 101 BGE: `alu_op`=10, `funct3_o`=010, taken when `zero`.
  - 110 BLTU: `alu_op`=10, `funct3_o`=011, taken when !`zero`.
  - 111 BGEU: `alu_op`=10, `funct3_o`=011, taken when `zero`.
  - 010 and 011 → ERROR; no PC write.
- EXECJALR: A=rs1, B=imm, `alu_op`=00. Next: JAL. rd is written only after the target is captured, so rd==rs1 is safe.
- JAL: `pc_write`=1, `pc_src`=1, A=OldPC, B=4, `alu_op`=00, `reg_write`=1, `result_src`=10, `instr_done`=1. Next: FETCH.
- ERROR: `illegal`=1. All strobes are 0. The unit stays in ERROR until `rst`.

## Timing
- Outputs are decoded combinationally from the state register and `instr`, `zero` and `mem_ready`.
- Reset: when `rst` is sampled high, the state becomes RESET at that edge. This applies mid-instruction too: `mem_req` and every strobe are 0 in the following cycle and no partial writes occur. `illegal` clears.
- Memory handshake:
  - `mem_req`, `mem_we` and `adr_src` stay stable until the cycle in which `mem_ready`=1.
  - A wait counter clears on entry to FETCH, MEMREAD and MEMWRITE and increments on each cycle with `mem_ready`=0.
  - If `mem_ready` is still 0 when the counter equals MEM_WAIT_MAX, the next state is ERROR.
  - `mem_ready` in that same cycle completes the access normally.
- Latency with zero-wait memory, in cycles:
  - AUIPC, branch, JAL: 3
  - R-type, I-ALU, LUI, JALR, store: 4
  - load: 5
  - Each wait cycle adds 1.
- `mem_ready` outside a request is ignored.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3) with `mem_ready` held 1 → the state sequence is RESET, FETCH, DECODE, EXECR, ALUWB. EXECR shows `alu_op`=10, `funct3_o`=000, `funct7_o`=0. `instr_done` pulses in cycle 4 after FETCH entry.
- ADDI x1,x0,-1 (0xFFF00093) → EXECI drives `funct7_o`=0. SRAI x1,x1,4 (0x4040D093) → `funct7_o`=0x20.
- BLT with `zero`=0 → `alu_op`=10, `funct3_o`=010, `pc_write`=1, `pc_src`=1. BGE with `zero`=0 → `pc_write`=0. Both take 3 cycles.
- LW with `mem_ready` low for 3 MEMREAD cycles → 8 cycles total and exactly one `reg_write` with `result_src`=01. `mem_ready` low for 16 FETCH cycles with MEM_WAIT_MAX=15 → ERROR, `illegal`=1.
- Opcode 0x7F, or branch funct3=010 → ERROR with no `pc_write` or `reg_write`. `rst` pulse → RESET, `illegal`=0, FETCH next.
- `rst` asserted during MEMWRITE wait → `mem_req`=0 the next cycle and no `instr_done` pulse.
